// File: rtl/sp3a_spi_pkg.sv
`default_nettype none
// ============================================================================
// Package : sp3a_spi_pkg
// Brief   : Shared definitions for the SP3A register-file SPI frame. Used by
//           both the FPGA-side controller and the on-FPGA target model.
// Rev     : 1.0  initial release
// ============================================================================
package sp3a_spi_pkg;

    // Header field widths
    localparam int SP3A_ADDR_BITS  = 8;
    localparam int SP3A_GROUP_BITS = 2;

    // Header field offsets, counted in edges after the last preamble bit
    localparam int SP3A_HDR_ADDR_OFS  = 0;
    localparam int SP3A_HDR_GROUP_OFS = SP3A_HDR_ADDR_OFS + SP3A_ADDR_BITS;
    localparam int SP3A_HDR_WE_OFS    = SP3A_HDR_GROUP_OFS + SP3A_GROUP_BITS;
    localparam int SP3A_HDR_ZERO_OFS  = SP3A_HDR_WE_OFS + 1;

    // Target frame-decoder states
    typedef enum logic [3:0] {
        ST_WAIT_HIGH = 4'd0,
        ST_IDLE      = 4'd1,
        ST_PREAMBLE  = 4'd2,
        ST_ADDR      = 4'd3,
        ST_GROUP     = 4'd4,
        ST_WE        = 4'd5,
        ST_ZERO      = 4'd6,
        ST_WRITE     = 4'd7,
        ST_READ      = 4'd8
    } sp3a_spi_target_state_t;

endpackage : sp3a_spi_pkg
`default_nettype wire

// File: rtl/sp3a_spi_target_regfile_if.sv
`default_nettype none
// ============================================================================
// Interface : sp3a_spi_target_regfile_if
// Brief     : Three-wire SPI bundle between the SP3A controller (master) and
//             the register-file target (slave). Clock is the shared axi_clk.
// Rev       : 1.0  initial release
// ============================================================================
interface sp3a_spi_target_regfile_if;
    logic cs_b;
    logic pico;
    logic poci;

    modport master (output cs_b, output pico, input  poci);
    modport slave  (input  cs_b, input  pico, output poci);
endinterface : sp3a_spi_target_regfile_if
`default_nettype wire

// File: rtl/sp3a_spi_target_regs.sv
`default_nettype none
// ============================================================================
// Module : sp3a_spi_target_regs
// Brief  : DEPTH x REG_W register bank with a masked merge-write port and two
//          asynchronous read ports (host peek and serial shifter load).
// Rev    : 1.0  initial release
// ============================================================================
module sp3a_spi_target_regs #(
    parameter int REG_W = 32,
    parameter int DEPTH = 16
) (
    input  wire                      axi_clk,
    input  wire                      reset,
    input  wire                      wr_en,
    input  wire [$clog2(DEPTH)-1:0]  wr_addr,
    input  wire [REG_W-1:0]          wr_data,
    input  wire [REG_W-1:0]          wr_mask,
    output logic [REG_W-1:0]         wr_merged,
    input  wire [$clog2(DEPTH)-1:0]  peek_addr,
    output logic [REG_W-1:0]         peek_data,
    input  wire [$clog2(DEPTH)-1:0]  ld_addr,
    output logic [REG_W-1:0]         ld_data
);

    logic [REG_W-1:0] r_mem [DEPTH];

    // Masked bits come from the new data, the rest keep the stored value
    always_comb begin
        wr_merged = (r_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        peek_data = r_mem[peek_addr];
        ld_data   = r_mem[ld_addr];
    end

    // Register bank storage; cleared by reset
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_merged;
        end
    end

endmodule : sp3a_spi_target_regs
`default_nettype wire

// File: rtl/sp3a_spi_target_regfile.sv
`default_nettype none
// ============================================================================
// Module : sp3a_spi_target_regfile
// Brief  : SP3A SPI target with a register bank. Decodes the LSB-first header
//          {preamble, addr, group, WE, zero}, then auto-increments through
//          consecutive words for write capture or read-back on poci.
// Config : define SP3A_SPI_TARGET_FRAME_CNT_EN to add the 16-bit frame_cnt
//          output counting completed WRITE/READ frames.
// Rev    : 1.0  initial release
// ============================================================================
module sp3a_spi_target_regfile
    import sp3a_spi_pkg::*;
#(
    parameter int                         REG_W         = 32,
    parameter int                         DEPTH         = 16,
    parameter logic [SP3A_GROUP_BITS-1:0] GROUP_ID      = 2'd0,
    parameter int                         PREAMBLE_BITS = 3
) (
    input  wire                          axi_clk,
    input  wire                          reset,
    sp3a_spi_target_regfile_if.slave     spi,
    input  wire  [$clog2(DEPTH)-1:0]     reg_rd_addr,
    output logic [REG_W-1:0]             reg_rd_data,
    output logic                         reg_wr_valid,
    output logic [$clog2(DEPTH)-1:0]     reg_wr_addr,
    output logic [REG_W-1:0]             reg_wr_data
`ifdef SP3A_SPI_TARGET_FRAME_CNT_EN
    ,
    output logic [15:0]                  frame_cnt
`endif
);

    localparam int c_aw  = $clog2(DEPTH);
    localparam int c_pw  = c_aw + 1;
    localparam int c_kw  = $clog2(REG_W);
    localparam int c_aiw = $clog2(SP3A_ADDR_BITS);
    localparam int c_giw = $clog2(SP3A_GROUP_BITS);

    // Edge indices within the frame; c0 is the IDLE edge that sees cs_b low
    localparam logic [7:0] c_pre_last    = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0] c_addr_first  = 8'(PREAMBLE_BITS + SP3A_HDR_ADDR_OFS);
    localparam logic [7:0] c_addr_last   = 8'(PREAMBLE_BITS + SP3A_HDR_GROUP_OFS - 1);
    localparam logic [7:0] c_group_first = 8'(PREAMBLE_BITS + SP3A_HDR_GROUP_OFS);
    localparam logic [7:0] c_group_last  = 8'(PREAMBLE_BITS + SP3A_HDR_WE_OFS - 1);
    localparam bit         c_pre_multi   = (PREAMBLE_BITS > 1);

    localparam logic [c_kw-1:0]           c_k_last  = c_kw'(REG_W - 1);
    localparam logic [c_pw-1:0]           c_depth_p = c_pw'(DEPTH);
    localparam logic [SP3A_ADDR_BITS:0]   c_depth_a = (SP3A_ADDR_BITS + 1)'(DEPTH);
    localparam logic [REG_W-1:0]          c_one     = REG_W'(1);

    sp3a_spi_target_state_t r_state, state_next;

    logic [7:0]                   r_cnt;
    logic [SP3A_ADDR_BITS-1:0]    r_addr;
    logic [SP3A_GROUP_BITS-1:0]   r_group;
    logic                         r_we;
    logic [c_pw-1:0]              r_ptr;
    logic [c_kw-1:0]              r_k;
    logic [REG_W-1:0]             r_wdata;
    logic [REG_W-1:0]             r_shift;
    logic                         r_poci;
    logic                         r_wr_valid;
    logic [c_aw-1:0]              r_wr_addr;
    logic [REG_W-1:0]             r_wr_data;

    logic [c_aiw-1:0]             w_addr_idx;
    logic [c_giw-1:0]             w_grp_idx;
    logic [SP3A_GROUP_BITS-1:0]   w_group_next;
    logic                         w_hdr_ok;
    logic                         w_cap_addr, w_cap_group, w_cap_we;
    logic                         w_ptr_load, w_rd_load, w_rd_step, w_wr_step;
    logic                         w_k_last, w_wr_full, w_wr_part, w_frame_done;
    logic [c_pw-1:0]              w_ptr_inc;
    logic                         w_ptr_ok;
    logic [c_aw-1:0]              w_ld_addr;
    logic                         w_ld_ok;
    logic [REG_W-1:0]             w_ld_raw, w_ld_word;
    logic [REG_W-1:0]             w_wr_word, w_part_mask;
    logic                         w_mem_we;
    logic [REG_W-1:0]             w_mem_mask, w_mem_merged;

    assign w_addr_idx = c_aiw'(r_cnt - c_addr_first);
    assign w_grp_idx  = c_giw'(r_cnt - c_group_first);

    // Group field as it will be once the current pico bit is included
    always_comb begin
        w_group_next            = r_group;
        w_group_next[w_grp_idx] = spi.pico;
        w_hdr_ok = (w_group_next == GROUP_ID) && ({1'b0, r_addr} < c_depth_a);
    end

    // State register
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            r_state <= ST_WAIT_HIGH;
        end else begin
            r_state <= state_next;
        end
    end

    // Next-state decode; a sampled cs_b high always returns to IDLE
    always_comb begin
        state_next = r_state;
        if (spi.cs_b) begin
            state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_WAIT_HIGH: state_next = ST_WAIT_HIGH;
                ST_IDLE:      state_next = c_pre_multi ? ST_PREAMBLE : ST_ADDR;
                ST_PREAMBLE:  if (r_cnt == c_pre_last)  state_next = ST_ADDR;
                ST_ADDR:      if (r_cnt == c_addr_last) state_next = ST_GROUP;
                ST_GROUP:     if (r_cnt == c_group_last)
                                  state_next = w_hdr_ok ? ST_WE : ST_WAIT_HIGH;
                ST_WE:        state_next = ST_ZERO;
                ST_ZERO:      state_next = r_we ? ST_WRITE : ST_READ;
                ST_WRITE:     state_next = ST_WRITE;
                ST_READ:      state_next = ST_READ;
                default:      state_next = ST_WAIT_HIGH;
            endcase
        end
    end

    // Per-state datapath strobes and register-bank port selection
    always_comb begin
        w_cap_addr   = !spi.cs_b && (r_state == ST_ADDR);
        w_cap_group  = !spi.cs_b && (r_state == ST_GROUP);
        w_cap_we     = !spi.cs_b && (r_state == ST_WE);
        w_ptr_load   = !spi.cs_b && (r_state == ST_ZERO);
        w_rd_load    = w_ptr_load && !r_we;
        w_rd_step    = !spi.cs_b && (r_state == ST_READ);
        w_wr_step    = !spi.cs_b && (r_state == ST_WRITE);
        w_k_last     = (r_k == c_k_last);
        w_wr_full    = w_wr_step && w_k_last;
        w_wr_part    = spi.cs_b && (r_state == ST_WRITE) && (r_k != '0);
        w_frame_done = spi.cs_b && ((r_state == ST_WRITE) || (r_state == ST_READ));

        w_ptr_inc    = r_ptr + 1'b1;
        w_ptr_ok     = (r_ptr < c_depth_p);

        // First read word comes from the header address, later ones from ptr+1;
        // past the end of the bank the shifter is fed zeros.
        if (r_state == ST_ZERO) begin
            w_ld_addr = r_addr[c_aw-1:0];
            w_ld_ok   = 1'b1;
        end else begin
            w_ld_addr = w_ptr_inc[c_aw-1:0];
            w_ld_ok   = (w_ptr_inc < c_depth_p);
        end
        w_ld_word = w_ld_ok ? w_ld_raw : '0;

        w_wr_word        = r_wdata;
        w_wr_word[r_k]   = spi.pico;
        w_part_mask      = (c_one << r_k) - c_one;
        w_mem_we         = (w_wr_full || w_wr_part) && w_ptr_ok;
        w_mem_mask       = w_wr_full ? '1 : w_part_mask;
    end

    sp3a_spi_target_regs #(
        .REG_W (REG_W),
        .DEPTH (DEPTH)
    ) u_regs (
        .axi_clk   (axi_clk),
        .reset     (reset),
        .wr_en     (w_mem_we),
        .wr_addr   (r_ptr[c_aw-1:0]),
        .wr_data   (w_wr_word),
        .wr_mask   (w_mem_mask),
        .wr_merged (w_mem_merged),
        .peek_addr (reg_rd_addr),
        .peek_data (reg_rd_data),
        .ld_addr   (w_ld_addr),
        .ld_data   (w_ld_raw)
    );

    // Header capture, word pointer, bit counter, shifters and poci
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_group    <= '0;
            r_we       <= 1'b0;
            r_ptr      <= '0;
            r_k        <= '0;
            r_wdata    <= '0;
            r_shift    <= '0;
            r_poci     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_mem_we;
            if (w_mem_we) begin
                r_wr_addr <= r_ptr[c_aw-1:0];
                r_wr_data <= w_mem_merged;
            end

            if (r_state == ST_IDLE) begin
                r_cnt <= 8'd1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_cap_addr)  r_addr[w_addr_idx] <= spi.pico;
            if (w_cap_group) r_group[w_grp_idx] <= spi.pico;
            if (w_cap_we)    r_we               <= spi.pico;

            if (w_ptr_load) begin
                r_ptr <= {1'b0, r_addr[c_aw-1:0]};
                r_k   <= '0;
            end

            if (w_rd_load) begin
                r_shift <= w_ld_word;
                r_poci  <= w_ld_word[0];
            end

            if (w_rd_step) begin
                if (w_k_last) begin
                    r_k     <= '0;
                    r_shift <= w_ld_word;
                    r_poci  <= w_ld_word[0];
                    if (w_ptr_ok) r_ptr <= w_ptr_inc;
                end else begin
                    r_k     <= r_k + 1'b1;
                    r_shift <= r_shift >> 1;
                    r_poci  <= r_shift[1];
                end
            end

            if (w_wr_step) begin
                r_wdata[r_k] <= spi.pico;
                if (w_k_last) begin
                    r_k <= '0;
                    if (w_ptr_ok) r_ptr <= w_ptr_inc;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end

            if (spi.cs_b) r_poci <= 1'b0;
        end
    end

    assign spi.poci     = r_poci;
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;

`ifdef SP3A_SPI_TARGET_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Count frames that reached the data phase, wrapping at 16 bits
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule : sp3a_spi_target_regfile
`default_nettype wire
